hamming_scrub_ctrl: RTL and testbench
=====================================

Name: hamming_scrub_ctrl

Overview:
- Controller that sequences the Hamming-protected 16-bit counter datapath.
- Gates the counter's enable and periodically freezes counting to run a scrub: check, correct single-bit upsets, re-verify.
- Flags uncorrectable errors and reports them.
- Sits beside the counter/parity datapath inside top, between the external enable and the datapath's enable, check and correction ports.

Parameters:
- SCRUB_PERIOD, 64, cycles spent in RUN between automatic scrubs (≥4)
- SYN_W, 5, syndrome width from the SEC-DED decoder (16 data bits)
- CHK_TIMEOUT, 8, max cycles waiting for chk_valid before declaring fault
- CNT_W, 8, width of corrected-error counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  external count request
- scrub_req  in  1  single-cycle request for an immediate scrub
- fault_clr  in  1  clears FAULT state and sticky flags
- chk_valid  in  1  decoder result valid (one cycle)
- syndrome  in  SYN_W  decoder syndrome
- ovr_par_err  in  1  overall-parity mismatch from decoder
- cnt_en  out  1  enable to counter datapath
- chk_start  out  1  one-cycle pulse: decoder samples stored word+parity
- corr_we  out  1  one-cycle pulse: datapath writes corrected word and regenerates parity
- busy  out  1  high in any state other than RUN
- fatal  out  1  sticky uncorrectable-error flag
- err_cause  out  2  0 none, 1 double error, 2 check timeout, 3 verify failed
- err_corr_cnt  out  CNT_W  saturating count of corrections

Behaviour:
- Reset (rst=0, async): state RUN, timer 0, pending 0.
- Reset values of outputs: cnt_en 0, chk_start 0, corr_we 0, busy 0, fatal 0, err_cause 0, err_corr_cnt 0.
- Reset asserted mid-scrub aborts the scrub immediately; no corr_we is issued.
- cnt_en = enable AND state==RUN. All other outputs are registered.
- States: RUN, DRAIN, CHECK, CORRECT, VERIFY, FAULT.
- RUN:
  - timer increments every cycle regardless of enable.
  - timer==SCRUB_PERIOD-1, or scrub_req, or pending=1 -> DRAIN.
  - timer clears on leaving RUN.
- DRAIN: one cycle, counter frozen so parity settles -> CHECK.
- CHECK:
  - chk_start pulses on the first cycle only; wait counter starts.
  - On chk_valid, classify:
    - syndrome==0, ovr==0: clean -> RUN.
    - syndrome!=0, ovr==1: single error -> CORRECT.
    - syndrome==0, ovr==1: parity-bit-only error -> CORRECT.
    - syndrome!=0, ovr==0: double error -> FAULT, err_cause=1.
  - No chk_valid within CHK_TIMEOUT cycles of chk_start -> FAULT, err_cause=2.
- CORRECT:
  - corr_we pulses for one cycle.
  - err_corr_cnt increments, saturating at all-ones.
  - -> VERIFY.
- VERIFY:
  - Issues chk_start and waits, with the same timeout as CHECK.
  - Clean -> RUN.
  - Any error -> FAULT, err_cause=3.
  - Timeout -> FAULT, err_cause=2.
- FAULT:
  - fatal=1, cnt_en=0, busy=1.
  - Stays until fault_clr=1 -> RUN; fatal, err_cause and timer clear.
  - err_corr_cnt is not cleared.
- scrub_req arriving outside RUN sets pending (one deep; further requests merge). pending clears on entering DRAIN.
- scrub_req on the same cycle the timer expires: a single scrub runs; pending is not set.
- chk_valid outside CHECK/VERIFY is ignored.
- fault_clr outside FAULT is ignored.
- Latency, automatic scrub: expiry at cycle T -> DRAIN at T+1 -> chk_start at T+2.
- Clean-path busy duration = 2 + decoder latency cycles.

Decomposition:
- Package hamming_ctrl_pkg holds:
  - state enum scrub_state_t.
  - err_cause constants ERR_NONE, ERR_DOUBLE, ERR_TIMEOUT, ERR_VERIFY.
  - function classify(syndrome, ovr) returning CLEAN/SINGLE/DOUBLE.
- One natural sub-module: scrub_timer (period counter with clear and expiry pulse).
- FSM, wait counter and statistics stay in hamming_scrub_ctrl.

Test Plan:
1. SCRUB_PERIOD=16, enable=1, decoder always clean with 1-cycle latency.
   - cnt_en drops for exactly 3 cycles every 19 cycles.
   - Counter advances 16 per period.
   - err_corr_cnt stays 0.
2. Inject syndrome=5'b00110, ovr=1 on first check; clean on verify.
   - Exactly one corr_we pulse, two chk_start pulses.
   - err_corr_cnt=1, fatal=0, counting resumes.
3. Inject syndrome=5'b00011, ovr=0.
   - FAULT, fatal=1, err_cause=1, cnt_en=0 despite enable=1.
   - fault_clr returns to RUN with fatal=0.
4. Never assert chk_valid.
   - FAULT exactly CHK_TIMEOUT=8 cycles after chk_start, err_cause=2.
5. Single error on check and again on verify.
   - FAULT with err_cause=3, err_corr_cnt=1.
6. Three scrub_req pulses during an active scrub.
   - Exactly one extra scrub after return to RUN.
   - Separately: rst=0 asserted while in CORRECT clears all outputs within the same cycle.

Source files
------------

// File: rtl/hamming_ctrl_pkg.sv
// Shared types and helpers for the Hamming scrub controller.
package hamming_ctrl_pkg;

   localparam int unsigned ERR_W   = 2;
   localparam int unsigned SYN_MAX = 16;

   localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
   localparam logic [ERR_W-1:0] ERR_DOUBLE  = 2'd1;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [ERR_W-1:0] ERR_VERIFY  = 2'd3;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_DRAIN,
      ST_CHECK,
      ST_CORRECT,
      ST_VERIFY,
      ST_FAULT
   } scrub_state_t;

   typedef enum logic [1:0] {
      CLEAN,
      SINGLE,
      DOUBLE
   } chk_class_t;

   // A parity-bit-only upset (zero syndrome, overall mismatch) is correctable like a data-bit upset.
   function automatic chk_class_t classify(input logic [SYN_MAX-1:0] syndrome, input logic ovr);
      chk_class_t cls;
      if (ovr)
         cls = SINGLE;
      else if (syndrome == '0)
         cls = CLEAN;
      else
         cls = DOUBLE;
      return cls;
   endfunction

endpackage

// File: rtl/hamming_scrub_ctrl_timer.sv
// Scrub period counter: counts while running, expiry flag on the last cycle of the period.
module scrub_timer #(
   parameter int unsigned PERIOD = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic expire_c
);

   localparam int unsigned TW = $clog2(PERIOD);

   logic [TW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (run)
         count <= count + TW'(1);
   end

   assign expire_c = run && (count == TW'(PERIOD - 1));

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Sequences the protected counter: gates counting, runs periodic/requested scrubs, reports faults.
module hamming_scrub_ctrl
   import hamming_ctrl_pkg::*;
#(
   parameter int unsigned SCRUB_PERIOD = 64,
   parameter int unsigned SYN_W        = 5,
   parameter int unsigned CHK_TIMEOUT  = 8,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             scrub_req,
   input  logic             fault_clr,
   input  logic             chk_valid,
   input  logic [SYN_W-1:0] syndrome,
   input  logic             ovr_par_err,
   output logic             cnt_en,
   output logic             chk_start,
   output logic             corr_we,
   output logic             busy,
   output logic             fatal,
   output logic [1:0]       err_cause,
   output logic [CNT_W-1:0] err_corr_cnt
);

   localparam int unsigned WAIT_W = $clog2(CHK_TIMEOUT + 1);

   scrub_state_t     state, next_state;
   chk_class_t       cls;
   logic             pending, pending_d;
   logic [WAIT_W-1:0] wait_cnt, wait_d;
   logic             chk_start_d, corr_we_d, busy_d, fatal_d;
   logic [1:0]       err_cause_d;
   logic [CNT_W-1:0] corr_cnt_d;
   logic             expire_c, timer_clr, timed_out;

   assign cls       = classify(SYN_MAX'(syndrome), ovr_par_err);
   assign timed_out = (wait_cnt == WAIT_W'(CHK_TIMEOUT - 1));
   assign timer_clr = (state != ST_RUN) || (next_state != ST_RUN);

   // Counting is only allowed in RUN and is forced low while reset is asserted.
   assign cnt_en = enable && rst && (state == ST_RUN);

   scrub_timer #(.PERIOD(SCRUB_PERIOD)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .run      (state == ST_RUN),
      .clr      (timer_clr),
      .expire_c (expire_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_RUN;
         pending      <= 1'b0;
         wait_cnt     <= '0;
         chk_start    <= 1'b0;
         corr_we      <= 1'b0;
         busy         <= 1'b0;
         fatal        <= 1'b0;
         err_cause    <= ERR_NONE;
         err_corr_cnt <= '0;
      end else begin
         state        <= next_state;
         pending      <= pending_d;
         wait_cnt     <= wait_d;
         chk_start    <= chk_start_d;
         corr_we      <= corr_we_d;
         busy         <= busy_d;
         fatal        <= fatal_d;
         err_cause    <= err_cause_d;
         err_corr_cnt <= corr_cnt_d;
      end
   end

   always_comb begin
      next_state  = state;
      pending_d   = pending;
      wait_d      = '0;
      err_cause_d = err_cause;
      corr_cnt_d  = err_corr_cnt;

      case (state)
         ST_RUN: begin
            if (expire_c || scrub_req || pending)
               next_state = ST_DRAIN;
         end
         ST_DRAIN:   next_state = ST_CHECK;
         ST_CHECK, ST_VERIFY: begin
            wait_d = wait_cnt + WAIT_W'(1);
            if (chk_valid) begin
               if (cls == CLEAN) begin
                  next_state = ST_RUN;
               end else if (state == ST_CHECK && cls == SINGLE) begin
                  next_state = ST_CORRECT;
               end else begin
                  next_state  = ST_FAULT;
                  err_cause_d = (state == ST_VERIFY) ? ERR_VERIFY : ERR_DOUBLE;
               end
            end else if (timed_out) begin
               next_state  = ST_FAULT;
               err_cause_d = ERR_TIMEOUT;
            end
         end
         ST_CORRECT: next_state = ST_VERIFY;
         ST_FAULT: begin
            if (fault_clr) begin
               next_state  = ST_RUN;
               err_cause_d = ERR_NONE;
            end
         end
         default:    next_state = ST_RUN;
      endcase

      // Requests during a scrub collapse into a single follow-up scrub.
      if (next_state == ST_DRAIN)
         pending_d = 1'b0;
      else if (scrub_req && state != ST_RUN)
         pending_d = 1'b1;

      chk_start_d = (state == ST_DRAIN   && next_state == ST_CHECK) ||
                    (state == ST_CORRECT && next_state == ST_VERIFY);
      corr_we_d   = (next_state == ST_CORRECT) && (state != ST_CORRECT);
      busy_d      = (next_state != ST_RUN);
      fatal_d     = (next_state == ST_FAULT);

      if (corr_we_d && err_corr_cnt != '1)
         corr_cnt_d = err_corr_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl with a 1-cycle-latency decoder model.
module tb_hamming_scrub_ctrl;

   localparam int unsigned SYN_W = 5;
   localparam int unsigned CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             enable;
   logic             scrub_req;
   logic             fault_clr;
   logic             chk_valid;
   logic [SYN_W-1:0] syndrome;
   logic             ovr_par_err;
   logic             cnt_en;
   logic             chk_start;
   logic             corr_we;
   logic             busy;
   logic             fatal;
   logic [1:0]       err_cause;
   logic [CNT_W-1:0] err_corr_cnt;

   int total = 0;
   int bad   = 0;
   int n_start = 0;
   int n_corr  = 0;
   int n_cnt   = 0;

   bit               dec_on = 1'b1;
   bit               resp_pend = 1'b0;
   logic [SYN_W-1:0] rs;
   logic             ro;
   logic [SYN_W-1:0] q_syn[$];
   logic             q_ovr[$];

   hamming_scrub_ctrl #(
      .SCRUB_PERIOD (16),
      .SYN_W        (SYN_W),
      .CHK_TIMEOUT  (8),
      .CNT_W        (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .scrub_req    (scrub_req),
      .fault_clr    (fault_clr),
      .chk_valid    (chk_valid),
      .syndrome     (syndrome),
      .ovr_par_err  (ovr_par_err),
      .cnt_en       (cnt_en),
      .chk_start    (chk_start),
      .corr_we      (corr_we),
      .busy         (busy),
      .fatal        (fatal),
      .err_cause    (err_cause),
      .err_corr_cnt (err_corr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decoder model answers one cycle after chk_start; also tallies pulses and counting cycles.
   always @(negedge clk) begin
      if (resp_pend) begin
         chk_valid   = 1'b1;
         syndrome    = rs;
         ovr_par_err = ro;
      end else begin
         chk_valid   = 1'b0;
         syndrome    = '0;
         ovr_par_err = 1'b0;
      end
      resp_pend = 1'b0;
      if (chk_start === 1'b1 && dec_on) begin
         resp_pend = 1'b1;
         if (q_syn.size() > 0) begin
            rs = q_syn.pop_front();
            ro = q_ovr.pop_front();
         end else begin
            rs = '0;
            ro = 1'b0;
         end
      end
      if (chk_start === 1'b1) n_start++;
      if (corr_we === 1'b1) n_corr++;
      if (cnt_en === 1'b1) n_cnt++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic count_level(input logic val, output int n);
      n = 0;
      while (cnt_en === val && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic pulse_req();
      scrub_req = 1'b1;
      tick();
      scrub_req = 1'b0;
   endtask

   task automatic pulse_clr();
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      enable = 1'b1;
      repeat (2) tick();
      total++;
      if ({cnt_en, chk_start, corr_we, busy, fatal, err_cause, err_corr_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got cnt_en=%b chk_start=%b corr_we=%b busy=%b fatal=%b cause=%0d cnt=%0d want all 0",
                  cnt_en, chk_start, corr_we, busy, fatal, err_cause, err_corr_cnt);
      end
      rst = 1'b1;
      tick();
      total++;
      if (cnt_en !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got cnt_en=%b busy=%b want 1 0", cnt_en, busy);
      end
   endtask

   task automatic test_periodic();
      int n, c0, c1;
      n = 0;
      while (cnt_en !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (cnt_en !== 1'b0 || busy !== 1'b1 || chk_start !== 1'b0) begin
         bad++;
         $display("FAIL periodic_drain: got cnt_en=%b busy=%b chk_start=%b want 0 1 0", cnt_en, busy, chk_start);
      end
      c0 = n_cnt;
      tick();
      total++;
      if (chk_start !== 1'b1) begin
         bad++;
         $display("FAIL chk_start_latency: got %b want 1", chk_start);
      end
      tick();
      total++;
      if (chk_start !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL check_wait: got chk_start=%b busy=%b want 0 1", chk_start, busy);
      end
      tick();
      count_level(1'b1, n);
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL run_len: got %0d want 16", n);
      end
      c1 = n_cnt;
      total++;
      if (c1 - c0 != 16) begin
         bad++;
         $display("FAIL count_advance: got %0d want 16", c1 - c0);
      end
      count_level(1'b0, n);
      total++;
      if (n != 3) begin
         bad++;
         $display("FAIL drop_len: got %0d want 3", n);
      end
      count_level(1'b1, n);
      total++;
      if (n != 16 || err_corr_cnt !== 8'd0) begin
         bad++;
         $display("FAIL second_period: got run=%0d corr_cnt=%0d want 16 0", n, err_corr_cnt);
      end
   endtask

   task automatic test_single();
      int n;
      wait_idle();
      q_syn.push_back(5'b00110);
      q_ovr.push_back(1'b1);
      n_start = 0;
      n_corr  = 0;
      pulse_req();
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (n != 6) begin
         bad++;
         $display("FAIL single_busy_len: got %0d want 6", n);
      end
      total++;
      if (n_start != 2 || n_corr != 1) begin
         bad++;
         $display("FAIL single_pulses: got chk_start=%0d corr_we=%0d want 2 1", n_start, n_corr);
      end
      total++;
      if (err_corr_cnt !== 8'd1 || fatal !== 1'b0 || cnt_en !== 1'b1) begin
         bad++;
         $display("FAIL single_result: got cnt=%0d fatal=%b cnt_en=%b want 1 0 1", err_corr_cnt, fatal, cnt_en);
      end
   endtask

   task automatic test_double();
      int n;
      wait_idle();
      q_syn.push_back(5'b00011);
      q_ovr.push_back(1'b0);
      pulse_req();
      n = 0;
      while (fatal !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      repeat (3) tick();
      total++;
      if (fatal !== 1'b1 || err_cause !== 2'd1 || cnt_en !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL double_fault: got fatal=%b cause=%0d cnt_en=%b busy=%b want 1 1 0 1",
                  fatal, err_cause, cnt_en, busy);
      end
      pulse_clr();
      total++;
      if (fatal !== 1'b0 || err_cause !== 2'd0 || busy !== 1'b0 || cnt_en !== 1'b1 || err_corr_cnt !== 8'd1) begin
         bad++;
         $display("FAIL double_clear: got fatal=%b cause=%0d busy=%b cnt_en=%b cnt=%0d want 0 0 0 1 1",
                  fatal, err_cause, busy, cnt_en, err_corr_cnt);
      end
   endtask

   task automatic test_timeout();
      int n;
      wait_idle();
      dec_on = 1'b0;
      pulse_req();
      n = 0;
      while (chk_start !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      n = 0;
      while (fatal !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (n != 8 || err_cause !== 2'd2) begin
         bad++;
         $display("FAIL timeout: got cycles=%0d cause=%0d want 8 2", n, err_cause);
      end
      dec_on = 1'b1;
      pulse_clr();
   endtask

   task automatic test_verify_fail();
      int n;
      wait_idle();
      q_syn.push_back(5'b00110);
      q_ovr.push_back(1'b1);
      q_syn.push_back(5'b00110);
      q_ovr.push_back(1'b1);
      n_corr = 0;
      pulse_req();
      n = 0;
      while (fatal !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (fatal !== 1'b1 || err_cause !== 2'd3 || err_corr_cnt !== 8'd2 || n_corr != 1) begin
         bad++;
         $display("FAIL verify_fail: got fatal=%b cause=%0d cnt=%0d corr_we=%0d want 1 3 2 1",
                  fatal, err_cause, err_corr_cnt, n_corr);
      end
      pulse_clr();
   endtask

   task automatic test_back_to_back();
      int n, extra;
      wait_idle();
      q_syn.push_back(5'b00110);
      q_ovr.push_back(1'b1);
      n_start = 0;
      n_corr  = 0;
      scrub_req = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         scrub_req = (i % 2 == 1);
         tick();
      end
      scrub_req = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_gap: got busy=%b want 0", busy);
      end
      tick();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_extra_start: got busy=%b want 1", busy);
      end
      wait_idle();
      extra = 0;
      repeat (10) begin
         tick();
         if (busy === 1'b1) extra++;
      end
      total++;
      if (extra != 0 || n_start != 3 || n_corr != 1) begin
         bad++;
         $display("FAIL b2b_merge: got busy_after=%0d chk_start=%0d corr_we=%0d want 0 3 1", extra, n_start, n_corr);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      wait_idle();
      q_syn.push_back(5'b00110);
      q_ovr.push_back(1'b1);
      pulse_req();
      n = 0;
      while (corr_we !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      total++;
      if (corr_we !== 1'b1 || err_corr_cnt !== 8'd4) begin
         bad++;
         $display("FAIL reach_correct: got corr_we=%b cnt=%0d want 1 4", corr_we, err_corr_cnt);
      end
      rst = 1'b0;
      #1;
      total++;
      if ({cnt_en, chk_start, corr_we, busy, fatal, err_cause, err_corr_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_mid: got cnt_en=%b chk_start=%b corr_we=%b busy=%b fatal=%b cause=%0d cnt=%0d want all 0",
                  cnt_en, chk_start, corr_we, busy, fatal, err_cause, err_corr_cnt);
      end
      n_corr  = 0;
      n_start = 0;
      tick();
      q_syn.delete();
      q_ovr.delete();
      rst = 1'b1;
      repeat (12) tick();
      total++;
      if (n_corr != 0 || n_start != 0 || busy !== 1'b0 || cnt_en !== 1'b1) begin
         bad++;
         $display("FAIL reset_abort: got corr_we=%0d chk_start=%0d busy=%b cnt_en=%b want 0 0 0 1",
                  n_corr, n_start, busy, cnt_en);
      end
   endtask

   initial begin
      rst         = 1'b1;
      enable      = 1'b0;
      scrub_req   = 1'b0;
      fault_clr   = 1'b0;
      chk_valid   = 1'b0;
      syndrome    = '0;
      ovr_par_err = 1'b0;
      test_reset();
      test_periodic();
      test_single();
      test_double();
      test_timeout();
      test_verify_fail();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
